stl_set_bit_iter: RTL and testbench



---
 rtl/stl_set_bit_iter.sv | 135 +++++++++++++
 tb/tb_stl_set_bit_iter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stl_set_bit_iter.sv
// ---------------------------------------------------------------------------
// stl_set_bit_iter
//   Serialises a DW-bit mask into one beat per set bit, lowest index first,
//   then retires the mask. The lowest set bit of the remaining mask is found
//   with a binary-tree trailing-zero counter.
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   in_valid     mask offered
//   in_ready     block accepts a mask this cycle (combinational from out_ready)
//   in_mask      DW-bit mask, sampled on in_valid & in_ready
//   out_valid    index beat valid
//   out_ready    downstream accepts the beat
//   out_idx      index of the lowest remaining set bit
//   out_seq      beat number within the current mask, from 0
//   out_last     this beat is the final set bit of the mask
//   zero_drop    one-cycle pulse after an all-zero mask is accepted
// ---------------------------------------------------------------------------
module stl_set_bit_iter #(
  parameter int DW = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_mask,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_idx,
  output logic [CW:0]   out_seq,
  output logic          out_last,
  output logic          zero_drop
);

  // Tree width: DW rounded up to a power of two; padding leaves are zero.
  localparam int P = 1 << CW;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_rem;
  logic [CW:0]   r_seq;
  logic          r_zero_drop;

  logic [P-1:0]  w_pad;
  logic          w_busy;
  logic          w_single;
  logic          w_accept;
  logic          w_beat;
  logic          w_mask_nz;

  // Binary-tree trailing-zero count. Each level merges pairs of nodes: the
  // parent is valid if either child is, and takes the lower child's index
  // when that child holds a set bit. The new MSB of the index records whether
  // the upper child was chosen. An all-zero input returns 0.
  function automatic logic [CW-1:0] tzc(input logic [P-1:0] v);
    logic [P-1:0]         v_cur;
    logic [P-1:0]         v_nxt;
    logic [P-1:0][CW-1:0] i_cur;
    logic [P-1:0][CW-1:0] i_nxt;
    v_cur = v;
    i_cur = '0;
    for (int l = 1; l <= CW; l++) begin
      v_nxt = '0;
      i_nxt = '0;
      for (int n = 0; n < (P >> l); n++) begin
        v_nxt[n]      = v_cur[2*n] | v_cur[2*n+1];
        i_nxt[n]      = v_cur[2*n] ? i_cur[2*n] : i_cur[2*n+1];
        i_nxt[n][l-1] = ~v_cur[2*n];
      end
      v_cur = v_nxt;
      i_cur = i_nxt;
    end
    return v_cur[0] ? i_cur[0] : '0;
  endfunction

  always_comb begin
    w_pad         = '0;
    w_pad[DW-1:0] = r_rem;
  end

  assign w_busy    = (r_state == BUSY);
  // Gated by state so out_last reads 0 while idle (rem is 0 there).
  assign w_single  = w_busy & ((r_rem & (r_rem - 1'b1)) == '0);
  assign w_mask_nz = (in_mask != '0);

  // out_ready -> in_ready is combinational so a new mask can be accepted in
  // the final-beat cycle of the previous one, giving back-to-back beats.
  assign in_ready  = ~w_busy | (out_ready & w_single);
  assign w_accept  = in_valid & in_ready;
  assign w_beat    = w_busy & out_ready;

  assign out_valid = w_busy;
  assign out_idx   = tzc(w_pad);
  assign out_seq   = r_seq;
  assign out_last  = w_single;
  assign zero_drop = r_zero_drop;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept && w_mask_nz) w_state_nxt = BUSY;
      BUSY: if (w_beat && w_single)
              w_state_nxt = (w_accept && w_mask_nz) ? BUSY : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_seq       <= '0;
      r_zero_drop <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_zero_drop <= w_accept & ~w_mask_nz;
      // Accept wins: in BUSY it only happens alongside the final beat.
      if (w_accept) begin
        r_rem <= in_mask;
        r_seq <= '0;
      end else if (w_beat) begin
        r_rem <= r_rem & (r_rem - 1'b1);
        r_seq <= r_seq + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stl_set_bit_iter.sv
module tb_stl_set_bit_iter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_mask;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [3:0] out_seq;
  logic       out_last;
  logic       zero_drop;

  logic       in_valid5;
  logic       in_ready5;
  logic [4:0] in_mask5;
  logic       out_valid5;
  logic [2:0] out_idx5;
  logic [3:0] out_seq5;
  logic       out_last5;
  logic       zero_drop5;

  typedef struct {
    int idx;
    int seq;
    int last;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  stl_set_bit_iter #(.DW(8), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_seq(out_seq), .out_last(out_last),
    .zero_drop(zero_drop)
  );

  stl_set_bit_iter #(.DW(5), .CW(3)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_mask(in_mask5),
    .out_valid(out_valid5), .out_ready(1'b1),
    .out_idx(out_idx5), .out_seq(out_seq5), .out_last(out_last5),
    .zero_drop(zero_drop5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one beat per set bit, LSB first.
  task automatic push_beats(input logic [7:0] m);
    int s;
    logic [7:0] rest;
    beat_t b;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        rest   = m >> (i + 1);
        b.idx  = i;
        b.seq  = s;
        b.last = (rest == 8'h00) ? 1 : 0;
        q.push_back(b);
        s++;
      end
    end
  endtask

  // Scoreboard: every transferred beat must match the head of the queue.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_beat", int'(out_idx), -1);
      end else begin
        e = q.pop_front();
        check("beat_idx", int'(out_idx), e.idx);
        check("beat_seq", int'(out_seq), e.seq);
        check("beat_last", int'(out_last), e.last);
        check("beat_in_ready", int'(in_ready), e.last);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] m);
    int waited;
    in_valid = 1'b1;
    in_mask  = m;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    check("send_accept_timeout", (waited < 100) ? 1 : 0, 1);
    push_beats(m);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((out_valid || q.size() != 0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain_timeout", (n < 200) ? 1 : 0, 1);
    check("drain_queue_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b1;
    in_valid5 = 1'b0;
    in_mask5  = '0;

    // Reset state
    @(negedge clk);
    in_valid = 1'b1;
    in_mask  = 8'hFF;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_seq", int'(out_seq), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_zero_drop", int'(zero_drop), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("rst_ignores_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic mask, full out_ready
    send(8'hA6);
    wait_idle();

    // Back-to-back masks with no bubble
    in_valid = 1'b1;
    in_mask  = 8'h81;
    @(negedge clk);
    check("b2b_idle_ready", int'(in_ready), 1);
    push_beats(8'h81);
    @(posedge clk);
    #1 in_mask = 8'h10;
    @(negedge clk);
    check("b2b_first_idx", int'(out_idx), 0);
    check("b2b_ready_low", int'(in_ready), 0);
    @(negedge clk);
    check("b2b_last_idx", int'(out_idx), 7);
    check("b2b_ready_high", int'(in_ready), 1);
    push_beats(8'h10);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b_no_bubble_valid", int'(out_valid), 1);
    check("b2b_no_bubble_idx", int'(out_idx), 4);
    @(posedge clk);
    #1;
    wait_idle();

    // Backpressure: outputs hold while out_ready is low
    out_ready = 1'b0;
    send(8'h0C);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) out_ready = 1'b1;
      @(negedge clk);
      check("stall_valid", int'(out_valid), 1);
      check("stall_idx", int'(out_idx), 2);
      check("stall_seq", int'(out_seq), 0);
      check("stall_last", int'(out_last), 0);
      check("stall_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    wait_idle();

    // Zero mask: no beats, one-cycle zero_drop pulse
    send(8'h00);
    @(negedge clk);
    check("zero_drop_pulse", int'(zero_drop), 1);
    check("zero_no_valid", int'(out_valid), 0);
    check("zero_in_ready", int'(in_ready), 1);
    @(negedge clk);
    check("zero_drop_cleared", int'(zero_drop), 0);
    check("zero_still_no_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // Extremes
    send(8'hFF);
    wait_idle();
    send(8'h80);
    @(negedge clk);
    check("msb_only_idx", int'(out_idx), 7);
    check("msb_only_last", int'(out_last), 1);
    @(posedge clk);
    #1;
    wait_idle();

    // Async reset mid-mask, right after beat idx 4 transfers
    send(8'hF0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_idx", int'(out_idx), 0);
    check("arst_seq", int'(out_seq), 0);
    check("arst_last", int'(out_last), 0);
    check("arst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_no_partial", int'(out_valid), 0);
    check("arst_release_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    send(8'h02);
    wait_idle();

    // Odd width: DW=5
    in_valid5 = 1'b1;
    in_mask5  = 5'b10001;
    @(negedge clk);
    check("dw5_ready", int'(in_ready5), 1);
    @(posedge clk);
    #1 in_valid5 = 1'b0;
    @(negedge clk);
    check("dw5_b0_valid", int'(out_valid5), 1);
    check("dw5_b0_idx", int'(out_idx5), 0);
    check("dw5_b0_last", int'(out_last5), 0);
    @(negedge clk);
    check("dw5_b1_valid", int'(out_valid5), 1);
    check("dw5_b1_idx", int'(out_idx5), 4);
    check("dw5_b1_seq", int'(out_seq5), 1);
    check("dw5_b1_last", int'(out_last5), 1);
    @(negedge clk);
    check("dw5_done", int'(out_valid5), 0);
    check("dw5_no_zero_drop", int'(zero_drop5), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
